// File: rtl/psum_accum_argmax.sv
// Accumulates NUM_TILES packed partial-sum vectors per lane, then scans the lanes for the argmax.
// Define PSUM_ACC_SAT_EN for saturating accumulation; the default build wraps in two's complement.
module psum_accum_argmax #(
  parameter int NUM_LANES = 10,
  parameter int PSUM_W    = 16,
  parameter int ACC_W     = 20,
  parameter int NUM_TILES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          soft_clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES*PSUM_W-1:0]   psum_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES*ACC_W-1:0]    acc_out,
  output logic [3:0]                    class_idx,
  output logic signed [ACC_W-1:0]       class_val,
  output logic                          ovf
);

  localparam int              CNT_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(NUM_TILES - 1);
  localparam logic [3:0]      LAST_LANE = 4'(NUM_LANES - 1);
`ifdef PSUM_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tile_cnt;
  logic [3:0]       r_scan_idx;
  logic [ACC_W-1:0] r_acc     [NUM_LANES];
  logic [ACC_W-1:0] w_acc_nxt [NUM_LANES];
  logic [NUM_LANES-1:0] w_lane_ovf;
  logic [ACC_W-1:0] r_best_val;
  logic [3:0]       r_best_idx;
  logic             r_ovf;
  logic             w_accept;
  logic             w_first;
  logic             w_last_tile;
  logic [ACC_W-1:0] w_scan_val;

  assign in_ready    = (r_state == ST_ACCUM);
  assign out_valid   = (r_state == ST_DONE);
  assign w_accept    = in_valid && in_ready && !soft_clr;
  assign w_first     = (r_tile_cnt == '0);
  assign w_last_tile = (r_tile_cnt == LAST_TILE);
  assign w_scan_val  = r_acc[r_scan_idx];
  assign class_idx   = r_best_idx;
  assign class_val   = r_best_val;
  assign ovf         = r_ovf;

  // One adder per lane; the first tile of a result loads instead of adding.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [PSUM_W-1:0] w_psum;
    logic [ACC_W:0]    w_ext;
    logic [ACC_W:0]    w_sum;
    logic              w_add_ovf;

    assign w_psum    = psum_in[(NUM_LANES-1-k)*PSUM_W +: PSUM_W];
    assign w_ext     = {{(ACC_W+1-PSUM_W){w_psum[PSUM_W-1]}}, w_psum};
    assign w_sum     = {r_acc[k][ACC_W-1], r_acc[k]} + w_ext;
    assign w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef PSUM_ACC_SAT_EN
    assign w_acc_nxt[k] = w_first    ? w_ext[ACC_W-1:0] :
                          !w_add_ovf ? w_sum[ACC_W-1:0] :
                          w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
`else
    assign w_acc_nxt[k] = w_first ? w_ext[ACC_W-1:0] : w_sum[ACC_W-1:0];
`endif
    assign w_lane_ovf[k] = !w_first && w_add_ovf;
    assign acc_out[(NUM_LANES-1-k)*ACC_W +: ACC_W] = r_acc[k];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && w_last_tile) w_state_nxt = ST_SCAN;
      ST_SCAN:  if (r_scan_idx == LAST_LANE) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)               w_state_nxt = ST_ACCUM;
      default:                               w_state_nxt = ST_ACCUM;
    endcase
    if (soft_clr) w_state_nxt = ST_ACCUM;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_ACCUM;
    else      r_state <= w_state_nxt;
  end

  // NOTE: the accumulator array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_LANES; k++) r_acc[k] <= '0;
      r_ovf <= 1'b0;
    end else if (soft_clr) begin
      for (int k = 0; k < NUM_LANES; k++) r_acc[k] <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_ovf <= (w_first ? 1'b0 : r_ovf) | (|w_lane_ovf);
    end
  end

  // Tile counter and sequential argmax scan; ties keep the lowest index via strict compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tile_cnt <= '0;
      r_scan_idx <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (soft_clr) begin
      r_tile_cnt <= '0;
      r_scan_idx <= '0;
    end else begin
      if (w_accept) r_tile_cnt <= w_last_tile ? '0 : r_tile_cnt + CNT_W'(1);
      if (r_state == ST_SCAN) begin
        r_scan_idx <= (r_scan_idx == LAST_LANE) ? '0 : r_scan_idx + 4'd1;
        if ((r_scan_idx == '0) || ($signed(w_scan_val) > $signed(r_best_val))) begin
          r_best_val <= w_scan_val;
          r_best_idx <= r_scan_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_argmax.sv
// Randomized bench for psum_accum_argmax: an ACC_W=20 and an ACC_W=17 instance run in lockstep
// against a per-tile arithmetic reference model (wrap or saturate following PSUM_ACC_SAT_EN).
module tb_psum_accum_argmax;

  localparam int NL = 10;
  localparam int PW = 16;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic soft_clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [NL*PW-1:0] psum_in = '0;

  logic in_ready0, out_valid0, ovf0;
  logic [NL*20-1:0] acc0;
  logic [3:0] idx0;
  logic signed [19:0] cval0;

  logic in_ready1, out_valid1, ovf1;
  logic [NL*17-1:0] acc1;
  logic [3:0] idx1;
  logic signed [16:0] cval1;

  int n_checks = 0;
  int n_fail   = 0;

  int     tile    [NT][NL];
  longint exp_acc [2][NL];
  bit     exp_ovf [2];
  int     exp_idx [2];
  longint exp_val [2];

  always #5 clk = ~clk;

  psum_accum_argmax #(.NUM_LANES(NL), .PSUM_W(PW), .ACC_W(20), .NUM_TILES(NT)) u_dut20 (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready0),
    .psum_in(psum_in), .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc0),
    .class_idx(idx0), .class_val(cval0), .ovf(ovf0));

  psum_accum_argmax #(.NUM_LANES(NL), .PSUM_W(PW), .ACC_W(17), .NUM_TILES(NT)) u_dut17 (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready1),
    .psum_in(psum_in), .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc1),
    .class_idx(idx1), .class_val(cval1), .ovf(ovf1));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: accumulate lane by lane with ideal integers, then apply the ACC_W range rule per add.
  task automatic model(input int d, input int w);
    longint hi, lo, span, s;
    hi   = (64'sd1 <<< (w - 1)) - 1;
    lo   = -(64'sd1 <<< (w - 1));
    span = 64'sd1 <<< w;
    exp_ovf[d] = 1'b0;
    for (int k = 0; k < NL; k++) begin
      s = tile[0][k];
      for (int t = 1; t < NT; t++) begin
        s = s + tile[t][k];
        if (s > hi || s < lo) begin
          exp_ovf[d] = 1'b1;
`ifdef PSUM_ACC_SAT_EN
          s = (s > hi) ? hi : lo;
`else
          s = (s > hi) ? s - span : s + span;
`endif
        end
      end
      exp_acc[d][k] = s;
    end
    exp_idx[d] = 0;
    exp_val[d] = exp_acc[d][0];
    for (int k = 1; k < NL; k++)
      if (exp_acc[d][k] > exp_val[d]) begin
        exp_idx[d] = k;
        exp_val[d] = exp_acc[d][k];
      end
  endtask

  function automatic logic [NL*PW-1:0] pack(input int t);
    logic [NL*PW-1:0] p;
    for (int k = 0; k < NL; k++) p[(NL-1-k)*PW +: PW] = tile[t][k][PW-1:0];
    return p;
  endfunction

  function automatic logic [NL*PW-1:0] junk();
    logic [NL*PW-1:0] p;
    for (int k = 0; k < NL; k++) p[(NL-1-k)*PW +: PW] = 16'($urandom);
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    logic signed [19:0] l0;
    logic signed [16:0] l1;
    for (int k = 0; k < NL; k++) begin
      l0 = acc0[(NL-1-k)*20 +: 20];
      l1 = acc1[(NL-1-k)*17 +: 17];
      check($sformatf("%s.acc20[%0d]", tag, k), longint'(l0), exp_acc[0][k]);
      check($sformatf("%s.acc17[%0d]", tag, k), longint'(l1), exp_acc[1][k]);
    end
    check({tag, ".idx20"}, longint'(idx0), exp_idx[0]);
    check({tag, ".idx17"}, longint'(idx1), exp_idx[1]);
    check({tag, ".val20"}, longint'(cval0), exp_val[0]);
    check({tag, ".val17"}, longint'(cval1), exp_val[1]);
    check({tag, ".ovf20"}, longint'(ovf0), longint'(exp_ovf[0]));
    check({tag, ".ovf17"}, longint'(ovf1), longint'(exp_ovf[1]));
  endtask

  // Sends the NT tiles in tile[][] and completes one result handshake. Called at posedge+1.
  task automatic run_result(input string tag, input int gap_max, input int stall, input bit hold_valid);
    int n, idle;
    model(0, 20);
    model(1, 17);
    out_ready = (stall == 0);
    for (int t = 0; t < NT; t++) begin
      idle = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < idle; g++) begin
        in_valid = 1'b0;
        psum_in  = junk();
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      psum_in  = pack(t);
      check({tag, ".in_ready"}, longint'({in_ready0, in_ready1}), 3);
      @(posedge clk); #1;
    end
    in_valid = hold_valid;
    psum_in  = junk();
    n = 1;
    while (!out_valid0 && n < 40) begin
      check({tag, ".scan_in_ready"}, longint'(in_ready0), 0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, NL + 1);
    check({tag, ".out_valid17"}, longint'(out_valid1), 1);
    for (int s = 0; s < stall; s++) begin
      check_outputs($sformatf("%s.stall%0d", tag, s));
      check({tag, ".stall_valid"}, longint'(out_valid0), 1);
      check({tag, ".stall_in_ready"}, longint'(in_ready0), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check_outputs(tag);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".valid_fall"}, longint'({out_valid0, out_valid1}), 0);
    check({tag, ".ready_back"}, longint'({in_ready0, in_ready1}), 3);
  endtask

  task automatic fill_random();
    for (int t = 0; t < NT; t++)
      for (int k = 0; k < NL; k++) tile[t][k] = int'($urandom_range(65535, 0)) - 32768;
  endtask

  initial begin
    int seen;
    #12;
    check("rst.out_valid", longint'({out_valid0, out_valid1}), 0);
    check("rst.acc_nz", longint'($countones(acc0) + $countones(acc1)), 0);
    check("rst.idx", longint'({idx0, idx1}), 0);
    check("rst.val", longint'(cval0) + longint'(cval1), 0);
    check("rst.ovf", longint'({ovf0, ovf1}), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst.in_ready", longint'({in_ready0, in_ready1}), 3);

    for (int t = 0; t < NT; t++) for (int k = 0; k < NL; k++) tile[t][k] = k + 1;
    run_result("basic", 0, 0, 1'b0);

    for (int t = 0; t < NT; t++) for (int k = 0; k < NL; k++) tile[t][k] = (k == 3 || k == 7) ? 25 : -50;
    run_result("tie", 0, 0, 1'b0);

    for (int t = 0; t < NT; t++) for (int k = 0; k < NL; k++) tile[t][k] = -1;
    run_result("neg1", 0, 0, 1'b0);

    for (int t = 0; t < NT; t++) for (int k = 0; k < NL; k++) tile[t][k] = k + 1;
    run_result("gap_bp", 3, 5, 1'b1);

    for (int t = 0; t < NT; t++) begin
      tile[t][0] = 32767;
      for (int k = 1; k < NL; k++) tile[t][k] = int'($urandom_range(200, 0)) - 100;
    end
    run_result("ovf", 0, 2, 1'b0);

    soft_clr = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0;
    check("sclr.ovf", longint'({ovf0, ovf1}), 0);
    check("sclr.state", longint'({out_valid0, in_ready0}), 1);
    fill_random();
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1; psum_in = pack(t);
      @(posedge clk); #1;
    end
    soft_clr = 1'b1; in_valid = 1'b1; psum_in = junk();
    @(posedge clk); #1;
    soft_clr = 1'b0; in_valid = 1'b0;
    check("sclr2.ovf", longint'({ovf0, ovf1}), 0);
    check("sclr2.state", longint'({out_valid0, in_ready0, in_ready1}), 3);
    for (int t = 0; t < NT; t++) for (int k = 0; k < NL; k++) tile[t][k] = 1;
    run_result("sclr_fresh", 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_result($sformatf("rnd%0d", r), int'($urandom_range(3, 0)), int'($urandom_range(4, 0)),
                 1'($urandom_range(1, 0)));
    end

    fill_random();
    for (int t = 0; t < NT; t++) begin
      in_valid = 1'b1; psum_in = pack(t);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check("mid_rst.out_valid", longint'({out_valid0, out_valid1}), 0);
    check("mid_rst.acc_nz", longint'($countones(acc0) + $countones(acc1)), 0);
    check("mid_rst.idx", longint'({idx0, idx1}), 0);
    check("mid_rst.ovf", longint'({ovf0, ovf1}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst.in_ready", longint'({in_ready0, in_ready1}), 3);
    seen = 0;
    for (int c = 0; c < 2 * NL; c++) begin
      if (out_valid0 || out_valid1) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst.no_emit", seen, 0);
    out_ready = 1'b0;

    fill_random();
    run_result("post_rst", 1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
